alarm_snooze_ctrl: RTL and testbench

ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

---
 rtl/alarm_snooze_ctrl_pkg.sv | 18 +
 rtl/alarm_sec_timer.sv | 50 +++++
 rtl/alarm_snooze_ctrl.sv | 142 ++++++++++++++
 tb/tb_alarm_snooze_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_snooze_ctrl_pkg.sv
// Shared definitions for the alarm snooze controller.
//   state_e            : controller state encoding (IDLE / RINGING / SNOOZE)
//   DEF_SNOOZE_SEC     : default snooze interval in seconds
//   DEF_RING_TIMEOUT   : default unattended ring time in seconds before auto-off
//   DEF_MAX_SNOOZE     : default number of snoozes allowed per alarm event
package alarm_snooze_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam int DEF_SNOOZE_SEC   = 300;
  localparam int DEF_RING_TIMEOUT = 60;
  localparam int DEF_MAX_SNOOZE   = 3;

endpackage

// File: rtl/alarm_sec_timer.sv
// Second counter shared by the ring timeout and the snooze interval.
// Counts up while ringing and down while snoozing; saturates at both ends.
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   clear          : force count to 0 (highest priority)
//   load, load_val : load a start value
//   count_up       : increment (saturating at all-ones)
//   count_down     : decrement (saturating at zero)
//   ring_done      : count is one below RING_TERM, so the next up-tick ends the ring
//   snooze_done    : count is 1, so the next down-tick ends the snooze
module alarm_sec_timer #(
  parameter int W         = 9,
  parameter int RING_TERM = 60
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count_up,
  input  logic         count_down,
  output logic         ring_done,
  output logic         snooze_done
);

  localparam logic [W-1:0] RING_LAST = W'(RING_TERM - 1);
  localparam logic [W-1:0] CNT_MAX   = {W{1'b1}};

  logic [W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count_up) begin
      if (count != CNT_MAX) count <= count + W'(1);
    end else if (count_down) begin
      if (count != '0) count <= count - W'(1);
    end
  end

  assign ring_done   = (count == RING_LAST);
  assign snooze_done = (count == W'(1));

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ringer controller: rings on a rising alarm-time match, supports a
// limited number of snoozes, and auto-stops after an unattended ring timeout.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   tick_1s      : one-clock pulse per second
//   match        : level, current time equals alarm time
//   alarm_en     : alarm armed; low forces IDLE
//   stop_alarm   : level, user stop request
//   snooze_req   : level, user snooze request
//   alarm        : ringer drive (state RINGING)
//   snoozing     : high in state SNOOZE
//   snooze_cnt   : snoozes used in the current alarm event
//   missed       : one-clock pulse when the ring times out
module alarm_snooze_ctrl
  import alarm_snooze_ctrl_pkg::*;
#(
  parameter int SNOOZE_SEC       = DEF_SNOOZE_SEC,
  parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT,
  parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE,
  localparam int SCW = $clog2(MAX_SNOOZE + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           tick_1s,
  input  logic           match,
  input  logic           alarm_en,
  input  logic           stop_alarm,
  input  logic           snooze_req,
  output logic           alarm,
  output logic           snoozing,
  output logic [SCW-1:0] snooze_cnt,
  output logic           missed
);

  localparam int CW = $clog2(((SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC
                                                              : RING_TIMEOUT_SEC) + 1);

  state_e         state, state_d;
  logic [SCW-1:0] snooze_cnt_d;
  logic           missed_d;
  logic           match_q;
  logic           primed;
  logic           trigger;
  logic           t_clear, t_load, t_up, t_down;
  logic           ring_done, snooze_done;

  // primed stays low for the first edge after reset so match_q holds a real
  // sample before any edge detection; a match level held through reset
  // therefore cannot look like a fresh 0->1 edge.
  assign trigger = primed & match & ~match_q & alarm_en;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d      = state;
    snooze_cnt_d = snooze_cnt;
    missed_d     = 1'b0;
    t_clear      = 1'b0;
    t_load       = 1'b0;
    t_up         = 1'b0;
    t_down       = 1'b0;

    if (!alarm_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state_d      = ST_RINGING;
            snooze_cnt_d = '0;
            t_clear      = 1'b1;
          end
        end
        ST_RINGING: begin
          if (stop_alarm) begin
            state_d = ST_IDLE;
          end else if (snooze_req && (snooze_cnt < SCW'(MAX_SNOOZE))) begin
            // An accepted snooze beats a simultaneous timeout tick.
            state_d      = ST_SNOOZE;
            snooze_cnt_d = snooze_cnt + SCW'(1);
            t_load       = 1'b1;
          end else if (tick_1s) begin
            if (ring_done) begin
              state_d  = ST_IDLE;
              missed_d = 1'b1;
            end else begin
              t_up = 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_alarm) begin
            state_d = ST_IDLE;
          end else if (tick_1s) begin
            if (snooze_done) begin
              state_d = ST_RINGING;
              t_clear = 1'b1;
            end else begin
              t_down = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      snooze_cnt <= '0;
      missed     <= 1'b0;
      match_q    <= 1'b0;
      primed     <= 1'b0;
    end else begin
      state      <= state_d;
      snooze_cnt <= snooze_cnt_d;
      missed     <= missed_d;
      match_q    <= match;
      primed     <= 1'b1;
    end
  end

  assign alarm    = (state == ST_RINGING);
  assign snoozing = (state == ST_SNOOZE);

  alarm_sec_timer #(
    .W         (CW),
    .RING_TERM (RING_TIMEOUT_SEC)
  ) u_sec_timer (
    .clock       (clock),
    .reset       (reset),
    .clear       (t_clear),
    .load        (t_load),
    .load_val    (CW'(SNOOZE_SEC)),
    .count_up    (t_up),
    .count_down  (t_down),
    .ring_done   (ring_done),
    .snooze_done (snooze_done)
  );

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl with SNOOZE_SEC=3, RING_TIMEOUT_SEC=5,
// MAX_SNOOZE=2. Inputs change 1 ns after a rising edge; outputs are checked
// 1 ns after the edge that should have produced them.
module tb_alarm_snooze_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_1s, match, alarm_en, stop_alarm, snooze_req;
  logic       alarm, snoozing, missed;
  logic [1:0] snooze_cnt;

  int errors = 0;
  int checks = 0;

  alarm_snooze_ctrl #(
    .SNOOZE_SEC       (3),
    .RING_TIMEOUT_SEC (5),
    .MAX_SNOOZE       (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick_1s    (tick_1s),
    .match      (match),
    .alarm_en   (alarm_en),
    .stop_alarm (stop_alarm),
    .snooze_req (snooze_req),
    .alarm      (alarm),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .missed     (missed)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cycle(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    cycle();
    tick_1s = 1'b0;
  endtask

  // Clean 0->1->0 match pulse; alarm rises on the first edge.
  task automatic fire();
    match = 1'b1;
    cycle();
    match = 1'b0;
    cycle();
  endtask

  task automatic snooze();
    snooze_req = 1'b1;
    cycle();
    snooze_req = 1'b0;
  endtask

  task automatic stop();
    stop_alarm = 1'b1;
    cycle();
    stop_alarm = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_1s = 1'b0; match = 1'b0; alarm_en = 1'b1;
    stop_alarm = 1'b0; snooze_req = 1'b0;
    #3;
    check("rst_alarm", alarm, 0);
    check("rst_snoozing", snoozing, 0);
    check("rst_cnt", snooze_cnt, 0);
    check("rst_missed", missed, 0);
    cycle(2);
    reset = 1'b0;
    cycle(2);

    // Basic ring and stop
    match = 1'b1;
    cycle();
    check("ring_on_match", alarm, 1);
    match = 1'b0;
    cycle();
    stop();
    check("stop_alarm_off", alarm, 0);
    check("stop_cnt", snooze_cnt, 0);

    // Snooze twice, third snooze ignored
    fire();
    snooze();
    check("sn1_snoozing", snoozing, 1);
    check("sn1_alarm", alarm, 0);
    check("sn1_cnt", snooze_cnt, 1);
    tick(); cycle(); tick();
    check("sn1_still_snooze", snoozing, 1);
    tick();
    check("sn1_ring_again", alarm, 1);
    snooze();
    check("sn2_cnt", snooze_cnt, 2);
    tick(); tick(); tick();
    check("sn2_ring_again", alarm, 1);
    snooze();
    check("sn3_ignored_alarm", alarm, 1);
    check("sn3_ignored_snoozing", snoozing, 0);
    check("sn3_cnt", snooze_cnt, 2);
    stop();
    cycle(2);
    check("idle_cnt_hold", snooze_cnt, 2);

    // Unattended ring times out on the fifth tick
    fire();
    check("trig_cnt_clear", snooze_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      cycle();
    end
    check("ring_before_timeout", alarm, 1);
    check("no_missed_early", missed, 0);
    tick();
    check("timeout_alarm", alarm, 0);
    check("timeout_missed", missed, 1);
    cycle();
    check("missed_one_cycle", missed, 0);

    // Stop, snooze and tick together: stop wins
    fire();
    snooze();
    tick(); tick(); tick();
    check("pre_combo_ring", alarm, 1);
    stop_alarm = 1'b1; snooze_req = 1'b1; tick_1s = 1'b1;
    cycle();
    stop_alarm = 1'b0; snooze_req = 1'b0; tick_1s = 1'b0;
    check("combo_alarm", alarm, 0);
    check("combo_snoozing", snoozing, 0);
    check("combo_cnt", snooze_cnt, 1);
    check("combo_missed", missed, 0);

    // Snooze beats a simultaneous timeout tick
    fire();
    repeat (4) tick();
    snooze_req = 1'b1; tick_1s = 1'b1;
    cycle();
    snooze_req = 1'b0; tick_1s = 1'b0;
    check("snooze_vs_tick_snoozing", snoozing, 1);
    check("snooze_vs_tick_missed", missed, 0);
    stop();
    check("stop_in_snooze", snoozing, 0);

    // Re-trigger while ringing does not restart the ring timeout
    fire();
    repeat (2) tick();
    fire();
    repeat (2) tick();
    check("retrig_still_ring", alarm, 1);
    tick();
    check("retrig_timeout_missed", missed, 1);
    check("retrig_timeout_alarm", alarm, 0);

    // alarm_en dropped during snooze
    fire();
    snooze();
    alarm_en = 1'b0;
    cycle();
    check("en_low_snoozing", snoozing, 0);
    alarm_en = 1'b1;
    repeat (3) tick();
    cycle();
    check("en_low_no_ring", alarm, 0);

    // Disarmed alarm ignores match
    alarm_en = 1'b0;
    fire();
    check("disarmed_no_ring", alarm, 0);
    alarm_en = 1'b1;

    // Reset mid-event with match held high
    match = 1'b1;
    cycle();
    check("held_ring", alarm, 1);
    snooze();
    check("held_snooze_cnt", snooze_cnt, 1);
    reset = 1'b1;
    #1;
    check("async_rst_snoozing", snoozing, 0);
    check("async_rst_cnt", snooze_cnt, 0);
    check("async_rst_alarm", alarm, 0);
    cycle();
    reset = 1'b0;
    cycle(3);
    check("no_retrig_after_rst", alarm, 0);
    match = 1'b0;
    cycle();
    check("match_fall_no_ring", alarm, 0);
    match = 1'b1;
    cycle();
    check("rearm_ring", alarm, 1);
    match = 1'b0;
    stop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
